// File: rtl/dmem_if.sv
// dmem_if
// Bundles the CPU data-memory port (d_mem_*), the write-trace stream
// (trace_*) and the responder status outputs (halt, halt_code, err_oob,
// trace_overflow_cnt) into one interface.
//
// Modports:
//   master : CPU / bench side. It drives the address, write data, byte
//            enables and trace_ready. It observes everything else.
//   slave  : dmem_responder side. This is the mirror image of master.
interface dmem_if;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] d_mem_rdata;

    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_wen;
    logic [15:0] trace_overflow_cnt;

    logic        halt;
    logic [31:0] halt_code;
    logic        err_oob;

    modport master (
        output d_mem_addr, d_mem_wdata, d_mem_wen, trace_ready,
        input  d_mem_rdata, trace_valid, trace_addr, trace_data, trace_wen,
               trace_overflow_cnt, halt, halt_code, err_oob
    );

    modport slave (
        input  d_mem_addr, d_mem_wdata, d_mem_wen, trace_ready,
        output d_mem_rdata, trace_valid, trace_addr, trace_data, trace_wen,
               trace_overflow_cnt, halt, halt_code, err_oob
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// This block is the slave end of the CPU load/store port. It contains:
//   - a byte-enabled word RAM,
//   - an MMIO window: the exit register at MMIO_BASE and a read-only RAM
//     write counter at MMIO_BASE+4,
//   - a show-ahead write-trace FIFO with valid/ready handshaking.
//
// Ports:
//   clk   : system clock. All state changes on its rising edge.
//   rst_n : synchronous active-low reset. RAM contents survive reset.
//   bus   : dmem_if.slave. Carries the d_mem_* bus, the trace_* stream and
//           the status outputs.
module dmem_responder #(
    parameter int unsigned MEM_SIZE_WORDS = 1024,
    parameter int unsigned TRACE_DEPTH    = 16,
    parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    localparam int unsigned AW        = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
    localparam int unsigned PW        = $clog2(TRACE_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_SIZE_WORDS);
    localparam logic [31:0] MMIO_CNT  = MMIO_BASE + 32'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wen;
    } trace_entry_t;

    logic [31:0]  mem_q  [MEM_SIZE_WORDS];
    trace_entry_t fifo_q [TRACE_DEPTH];

    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]  ovf_cnt_q, ovf_cnt_d;
    logic [31:0]  write_cnt_q, write_cnt_d;
    logic         halt_q, halt_d;
    logic [31:0]  halt_code_q, halt_code_d;
    logic         err_oob_q, err_oob_d;

    logic         ram_hit, is_exit, is_cnt;
    logic [AW-1:0] word_idx;
    logic         write_fire, ram_wr;
    logic         fifo_empty, fifo_full, pop, push_ok;

    assign ram_hit  = bus.d_mem_addr < RAM_BYTES;
    assign is_exit  = bus.d_mem_addr == MMIO_BASE;
    assign is_cnt   = bus.d_mem_addr == MMIO_CNT;
    assign word_idx = bus.d_mem_addr[AW+1:2];

    // A write is accepted only outside reset and before halt.
    // Every accepted write is traced, whatever it targets.
    assign write_fire = rst_n && (bus.d_mem_wen != 4'b0000) && !halt_q;
    assign ram_wr     = write_fire && ram_hit;

    // The pointers carry one extra wrap bit. Equal pointers mean empty.
    // Pointers that differ only in the wrap bit mean full.
    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop        = !fifo_empty && bus.trace_ready;
    // A full FIFO still accepts a push if the head leaves on the same edge.
    assign push_ok    = write_fire && (!fifo_full || pop);

    // Read path is combinational. Data stored at this edge shows up next cycle.
    always_comb begin
        bus.d_mem_rdata = 32'hDEAD_BEEF;
        if (ram_hit)      bus.d_mem_rdata = mem_q[word_idx];
        else if (is_exit) bus.d_mem_rdata = halt_code_q;
        else if (is_cnt)  bus.d_mem_rdata = write_cnt_q;
    end

    always_comb begin
        // NOTE: every next-state value starts from its current value, so no
        // path through this block leaves a variable unassigned (no latches).
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ovf_cnt_d   = ovf_cnt_q;
        write_cnt_d = write_cnt_q;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        err_oob_d   = err_oob_q;

        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (write_fire && !push_ok && ovf_cnt_q != 16'hFFFF)
            ovf_cnt_d = ovf_cnt_q + 16'd1;

        if (ram_wr) write_cnt_d = write_cnt_q + 32'd1;
        if (write_fire && is_exit && bus.d_mem_wen == 4'b1111) begin
            halt_d      = 1'b1;
            halt_code_d = bus.d_mem_wdata;
        end
        if (write_fire && !ram_hit && !is_exit && !is_cnt)
            err_oob_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers therefore sample their inputs from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_cnt_q   <= '0;
            write_cnt_q <= '0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            err_oob_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_cnt_q   <= ovf_cnt_d;
            write_cnt_q <= write_cnt_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            err_oob_q   <= err_oob_d;
        end
    end

    // NOTE: the RAM and FIFO storage arrays are deliberately left without
    // reset. This lets them map onto RAM primitives, and RAM contents must
    // survive rst_n. The pointers alone decide which FIFO slots are valid.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.d_mem_wen[i])
                    mem_q[word_idx][8*i +: 8] <= bus.d_mem_wdata[8*i +: 8];
            end
        end
        if (push_ok)
            fifo_q[wr_ptr_q[PW-1:0]] <= '{addr: bus.d_mem_addr,
                                          data: bus.d_mem_wdata,
                                          wen:  bus.d_mem_wen};
    end

    assign bus.trace_valid        = !fifo_empty;
    assign bus.trace_addr         = fifo_q[rd_ptr_q[PW-1:0]].addr;
    assign bus.trace_data         = fifo_q[rd_ptr_q[PW-1:0]].data;
    assign bus.trace_wen          = fifo_q[rd_ptr_q[PW-1:0]].wen;
    assign bus.trace_overflow_cnt = ovf_cnt_q;
    assign bus.halt               = halt_q;
    assign bus.halt_code          = halt_code_q;
    assign bus.err_oob            = err_oob_q;
endmodule
